// File: rtl/conv1d_pkg.sv
// Shared definitions for the Conv1D layer sequencer: state encoding, derived
// layer sizes and the address-width legality check.
package conv1d_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_LOAD_X,
      S_CLEAR,
      S_MAC,
      S_WRITE,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam int ADDR_BITS_MAX = 30;

   function automatic int out_len(input int input_size, input int kernel_size, input int stride);
      return (input_size - kernel_size) / stride + 1;
   endfunction

   function automatic int w_words(input int kernels, input int kernel_size);
      return kernels * kernel_size;
   endfunction

   function automatic int o_words(input int kernels, input int len);
      return kernels * len;
   endfunction

   // True when an address of 'bits' width can reach every index 0..count-1.
   function automatic bit fits(input int count, input int bits);
      return (bits >= 1) && (bits <= ADDR_BITS_MAX) && (count >= 1) && (count <= (1 << bits));
   endfunction

endpackage

// File: rtl/conv1d_stream_loader.sv
// Word counter with a ready/valid write-port driver; the counter wraps to zero
// on the last accepted word so the next phase starts from a clean address.
module conv1d_stream_loader #(
   parameter int ADDR_W = 4,
   parameter int WORDS  = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              active,
   input  logic              valid,
   output logic              ready,
   output logic              we,
   output logic              last,
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W-1:0] count;

   assign ready = active;
   assign we    = valid & active;
   assign last  = (count == ADDR_W'(WORDS - 1));
   assign addr  = count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (we) begin
         count <= last ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/conv1d_layer_sequencer.sv
// Controller for one Conv1D multi-kernel layer pass: load weights, load inputs,
// run clear/MAC/write per window, drain the output buffer, pulse done.
module conv1d_layer_sequencer
   import conv1d_pkg::*;
#(
   parameter int KERNEL_SIZE                = 3,
   parameter int KERNELS                    = 4,
   parameter int STRIDE                     = 1,
   parameter int INPUT_SIZE                 = 27,
   parameter int W_BUFFER_ADDRESS_BITS      = 4,
   parameter int INPUT_BUFFER_ADDRESS_BITS  = 5,
   parameter int OUTPUT_BUFFER_ADDRESS_BITS = 7
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   output logic                                  busy,
   output logic                                  done,
   input  logic                                  w_load_valid,
   output logic                                  w_load_ready,
   output logic                                  w_we,
   output logic [W_BUFFER_ADDRESS_BITS-1:0]      w_wr_address,
   input  logic                                  x_load_valid,
   output logic                                  x_load_ready,
   output logic                                  x_we,
   output logic [INPUT_BUFFER_ADDRESS_BITS-1:0]  x_wr_address,
   output logic [W_BUFFER_ADDRESS_BITS-1:0]      tap,
   output logic [INPUT_BUFFER_ADDRESS_BITS-1:0]  x_rd_address,
   output logic                                  clear,
   output logic                                  mac_en,
   output logic                                  write,
   output logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_index,
   output logic [OUTPUT_BUFFER_ADDRESS_BITS-1:0] out_rd_address,
   output logic                                  out_valid,
   input  logic                                  out_ready
);

   localparam int WA      = W_BUFFER_ADDRESS_BITS;
   localparam int IA      = INPUT_BUFFER_ADDRESS_BITS;
   localparam int OA      = OUTPUT_BUFFER_ADDRESS_BITS;
   localparam int OUT_LEN = out_len(INPUT_SIZE, KERNEL_SIZE, STRIDE);
   localparam int W_WORDS = w_words(KERNELS, KERNEL_SIZE);
   localparam int O_WORDS = o_words(KERNELS, OUT_LEN);

   if (STRIDE < 1 || OUT_LEN < 1 || !fits(W_WORDS, WA) || !fits(KERNEL_SIZE, WA) ||
       !fits(INPUT_SIZE, IA) || !fits(O_WORDS, OA)) begin : g_bad_params
      $error("conv1d_layer_sequencer: illegal parameter combination");
   end

   state_t          state, state_nx;
   logic [WA-1:0]   tap_q;
   logic [IA-1:0]   base_q;
   logic [OA-1:0]   window_q;
   logic            w_last, x_last, d_last, d_xfer;
   logic            last_tap, last_win;

   conv1d_stream_loader #(.ADDR_W(WA), .WORDS(W_WORDS)) u_w_loader (
      .clk(clk), .rst(rst), .active(state == S_LOAD_W), .valid(w_load_valid),
      .ready(w_load_ready), .we(w_we), .last(w_last), .addr(w_wr_address)
   );

   conv1d_stream_loader #(.ADDR_W(IA), .WORDS(INPUT_SIZE)) u_x_loader (
      .clk(clk), .rst(rst), .active(state == S_LOAD_X), .valid(x_load_valid),
      .ready(x_load_ready), .we(x_we), .last(x_last), .addr(x_wr_address)
   );

   // Drain reuses the loader with roles swapped: out_ready is the accepting side.
   conv1d_stream_loader #(.ADDR_W(OA), .WORDS(O_WORDS)) u_drain (
      .clk(clk), .rst(rst), .active(state == S_DRAIN), .valid(out_ready),
      .ready(out_valid), .we(d_xfer), .last(d_last), .addr(out_rd_address)
   );

   assign last_tap     = (tap_q == WA'(KERNEL_SIZE - 1));
   assign last_win     = (window_q == OA'(OUT_LEN - 1));
   assign tap          = tap_q;
   assign out_index    = window_q;
   assign x_rd_address = IA'((IA + 1)'(base_q) + (IA + 1)'(tap_q));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         tap_q    <= '0;
         base_q   <= '0;
         window_q <= '0;
      end else begin
         state <= state_nx;
         case (state)
            S_MAC:   tap_q <= last_tap ? '0 : tap_q + 1'b1;
            S_WRITE: begin
               if (last_win) begin
                  window_q <= '0;
                  base_q   <= '0;
               end else begin
                  window_q <= window_q + 1'b1;
                  base_q   <= IA'((IA + 1)'(base_q) + (IA + 1)'(STRIDE));
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      busy     = (state != S_IDLE);
      done     = 1'b0;
      clear    = 1'b0;
      mac_en   = 1'b0;
      write    = 1'b0;
      case (state)
         S_IDLE:   if (start) state_nx = S_LOAD_W;
         S_LOAD_W: if (w_we && w_last) state_nx = S_LOAD_X;
         S_LOAD_X: if (x_we && x_last) state_nx = S_CLEAR;
         S_CLEAR: begin
            clear    = 1'b1;
            state_nx = S_MAC;
         end
         S_MAC: begin
            mac_en = 1'b1;
            if (last_tap) state_nx = S_WRITE;
         end
         S_WRITE: begin
            write    = 1'b1;
            state_nx = last_win ? S_DRAIN : S_CLEAR;
         end
         S_DRAIN:  if (d_xfer && d_last) state_nx = S_DONE;
         S_DONE: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default:  state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_conv1d_layer_sequencer.sv
// Bench for conv1d_layer_sequencer: cycle-exact timing table, buffer/accumulator
// model with golden convolution, backpressure, reset mid-pass, stride-2 build.
module tb_conv1d_layer_sequencer;

   localparam int KS = 3;
   localparam int KN = 4;
   localparam int IN = 27;
   localparam int WA = 4;
   localparam int IA = 5;
   localparam int OA = 7;
   localparam int OL = 25;
   localparam int OW = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, w_load_valid, x_load_valid, out_ready;
   logic busy, done, w_load_ready, w_we, x_load_ready, x_we, clear, mac_en, write, out_valid;
   logic [WA-1:0] w_wr_address, tap;
   logic [IA-1:0] x_wr_address, x_rd_address;
   logic [OA-1:0] out_index, out_rd_address;

   logic s2_start;
   logic s2_busy, s2_done, s2_w_load_ready, s2_w_we, s2_x_load_ready, s2_x_we;
   logic s2_clear, s2_mac_en, s2_write, s2_out_valid;
   logic [WA-1:0] s2_w_wr_address, s2_tap;
   logic [IA-1:0] s2_x_wr_address, s2_x_rd_address;
   logic [OA-1:0] s2_out_index, s2_out_rd_address;

   conv1d_layer_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .w_load_valid(w_load_valid), .w_load_ready(w_load_ready), .w_we(w_we),
      .w_wr_address(w_wr_address), .x_load_valid(x_load_valid), .x_load_ready(x_load_ready),
      .x_we(x_we), .x_wr_address(x_wr_address), .tap(tap), .x_rd_address(x_rd_address),
      .clear(clear), .mac_en(mac_en), .write(write), .out_index(out_index),
      .out_rd_address(out_rd_address), .out_valid(out_valid), .out_ready(out_ready)
   );

   conv1d_layer_sequencer #(.STRIDE(2)) dut_s2 (
      .clk(clk), .rst(rst), .start(s2_start), .busy(s2_busy), .done(s2_done),
      .w_load_valid(1'b1), .w_load_ready(s2_w_load_ready), .w_we(s2_w_we),
      .w_wr_address(s2_w_wr_address), .x_load_valid(1'b1), .x_load_ready(s2_x_load_ready),
      .x_we(s2_x_we), .x_wr_address(s2_x_wr_address), .tap(s2_tap), .x_rd_address(s2_x_rd_address),
      .clear(s2_clear), .mac_en(s2_mac_en), .write(s2_write), .out_index(s2_out_index),
      .out_rd_address(s2_out_rd_address), .out_valid(s2_out_valid), .out_ready(1'b1)
   );

   typedef struct packed {
      logic          busy;
      logic          done;
      logic          w_load_ready;
      logic          w_we;
      logic [WA-1:0] w_wr_address;
      logic          x_load_ready;
      logic          x_we;
      logic [IA-1:0] x_wr_address;
      logic [WA-1:0] tap;
      logic [IA-1:0] x_rd_address;
      logic          clear;
      logic          mac_en;
      logic          write;
      logic [OA-1:0] out_index;
      logic [OA-1:0] out_rd_address;
      logic          out_valid;
   } obs_t;

   typedef struct {
      int   s;
      obs_t e;
   } vec_t;

   vec_t tab[$];
   int   errors = 0;
   int   checks = 0;

   // Buffer and accumulator model driven by the DUT strobes.
   int w_data, x_data;
   int w_mem[16];
   int x_mem[32];
   int acc[KN];
   int o_mem[128];

   always @(posedge clk) begin
      if (w_we) w_mem[w_wr_address] <= w_data;
      if (x_we) x_mem[x_wr_address] <= x_data;
      for (int k = 0; k < KN; k++) begin
         if (clear) acc[k] <= 0;
         else if (mac_en) acc[k] <= acc[k] + w_mem[k * KS + int'(tap)] * x_mem[x_rd_address];
         if (write) o_mem[k * OL + int'(out_index)] <= acc[k];
      end
   end

   function automatic obs_t sample();
      obs_t o;
      o.busy = busy; o.done = done; o.w_load_ready = w_load_ready; o.w_we = w_we;
      o.w_wr_address = w_wr_address; o.x_load_ready = x_load_ready; o.x_we = x_we;
      o.x_wr_address = x_wr_address; o.tap = tap; o.x_rd_address = x_rd_address;
      o.clear = clear; o.mac_en = mac_en; o.write = write; o.out_index = out_index;
      o.out_rd_address = out_rd_address; o.out_valid = out_valid;
      return o;
   endfunction

   function automatic obs_t sample2();
      obs_t o;
      o.busy = s2_busy; o.done = s2_done; o.w_load_ready = s2_w_load_ready; o.w_we = s2_w_we;
      o.w_wr_address = s2_w_wr_address; o.x_load_ready = s2_x_load_ready; o.x_we = s2_x_we;
      o.x_wr_address = s2_x_wr_address; o.tap = s2_tap; o.x_rd_address = s2_x_rd_address;
      o.clear = s2_clear; o.mac_en = s2_mac_en; o.write = s2_write; o.out_index = s2_out_index;
      o.out_rd_address = s2_out_rd_address; o.out_valid = s2_out_valid;
      return o;
   endfunction

   function automatic void add(input int s, input obs_t e);
      vec_t v;
      v.s = s;
      v.e = e;
      tab.push_back(v);
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One pass: s counts cycles from the start cycle (s=0, IDLE with start high).
   task automatic run_pass(input string tag, input bit bp, input bit tbl, input bit start_drain,
                           input int rst_win, input bit pre_started, input bit chain, input int wofs);
      int wn = 0, xn = 0, dn = 0, dones = 0, done_s = -1, ti = 0, g;
      bit excl_bad = 1'b0, finished = 1'b0, did_rst = 1'b0;
      int golden[OW];
      for (int k = 0; k < KN; k++)
         for (int j = 0; j < OL; j++) begin
            g = 0;
            for (int t = 0; t < KS; t++) g += j + t;
            golden[k * OL + j] = (k + 1 + wofs) * g;
         end
      for (int s = (pre_started ? 1 : 0); s < 3000 && !finished; s++) begin
         @(negedge clk);
         start        = (s == 0);
         w_load_valid = bp ? (s % 2 == 0) : 1'b1;
         x_load_valid = 1'b1;
         out_ready    = bp ? (s % 2 == 1) : 1'b1;
         w_data       = wn / KS + 1 + wofs;
         x_data       = xn;
         #1;
         if (tbl) begin
            while (ti < tab.size() && tab[ti].s < s) ti++;
            if (ti < tab.size() && tab[ti].s == s) begin
               chk($sformatf("%s obs@%0d", tag, s), sample(), tab[ti].e);
               ti++;
            end
         end
         if ($countones({clear, mac_en, write, w_we, x_we, out_valid}) > 1) excl_bad = 1'b1;
         if (w_we) begin
            chk($sformatf("%s w_wr_address", tag), w_wr_address, wn);
            wn++;
         end
         if (x_we) begin
            chk($sformatf("%s x_wr_address", tag), x_wr_address, xn);
            xn++;
         end
         if (out_valid) begin
            chk($sformatf("%s out_rd_address", tag), out_rd_address, dn);
            if (out_ready) begin
               chk($sformatf("%s out[%0d]", tag, dn), o_mem[out_rd_address], golden[dn]);
               dn++;
               if (start_drain && dn == 3) start = 1'b1;
            end
         end
         if (done) begin
            dones++;
            done_s = s;
         end
         if (done_s >= 0 && s == done_s + 1) begin
            chk($sformatf("%s busy after done", tag), busy, 0);
            finished = 1'b1;
            if (chain) start = 1'b1;
         end
         if (rst_win >= 0 && mac_en && int'(out_index) == rst_win) begin
            rst = 1'b1;
            @(negedge clk);
            rst   = 1'b0;
            start = 1'b0;
            #1;
            chk($sformatf("%s obs after reset", tag), sample(), 0);
            finished = 1'b1;
            did_rst  = 1'b1;
         end
      end
      if (!finished) chk($sformatf("%s timeout", tag), 0, 1);
      if (!did_rst) begin
         chk($sformatf("%s done pulses", tag), dones, 1);
         chk($sformatf("%s drained words", tag), dn, OW);
         chk($sformatf("%s weight words", tag), wn, KN * KS);
         chk($sformatf("%s input words", tag), xn, IN);
         if (!bp) chk($sformatf("%s done cycle", tag), done_s, 265);
      end
      chk($sformatf("%s strobe exclusivity", tag), excl_bad, 0);
   endtask

   task automatic run_stride();
      int nwin = 0, last_xra = -1, dones = 0, dn = 0;
      bit fin = 1'b0, excl_bad = 1'b0;
      for (int s = 0; s < 3000 && !fin; s++) begin
         @(negedge clk);
         s2_start = (s == 0);
         #1;
         if ($countones({s2_clear, s2_mac_en, s2_write, s2_w_we, s2_x_we, s2_out_valid}) > 1)
            excl_bad = 1'b1;
         if (s2_clear) begin
            chk($sformatf("stride base w%0d", nwin), s2_x_rd_address, 2 * nwin);
            chk($sformatf("stride index w%0d", nwin), s2_out_index, nwin);
            nwin++;
         end
         if (s2_mac_en) last_xra = int'(s2_x_rd_address);
         if (s2_out_valid) dn++;
         if (s2_done) begin
            dones++;
            fin = 1'b1;
         end
      end
      chk("stride windows", nwin, 13);
      chk("stride last x_rd_address", last_xra, 26);
      chk("stride drained words", dn, 52);
      chk("stride done pulses", dones, 1);
      chk("stride strobe exclusivity", excl_bad, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      add(0,   '{default: 0});
      add(1,   '{busy: 1, w_load_ready: 1, w_we: 1, default: 0});
      add(2,   '{busy: 1, w_load_ready: 1, w_we: 1, w_wr_address: 1, default: 0});
      add(12,  '{busy: 1, w_load_ready: 1, w_we: 1, w_wr_address: 11, default: 0});
      add(13,  '{busy: 1, x_load_ready: 1, x_we: 1, default: 0});
      add(39,  '{busy: 1, x_load_ready: 1, x_we: 1, x_wr_address: 26, default: 0});
      add(40,  '{busy: 1, clear: 1, default: 0});
      add(41,  '{busy: 1, mac_en: 1, default: 0});
      add(42,  '{busy: 1, mac_en: 1, tap: 1, x_rd_address: 1, default: 0});
      add(43,  '{busy: 1, mac_en: 1, tap: 2, x_rd_address: 2, default: 0});
      add(44,  '{busy: 1, write: 1, default: 0});
      add(45,  '{busy: 1, clear: 1, x_rd_address: 1, out_index: 1, default: 0});
      add(161, '{busy: 1, mac_en: 1, x_rd_address: 24, out_index: 24, default: 0});
      add(163, '{busy: 1, mac_en: 1, tap: 2, x_rd_address: 26, out_index: 24, default: 0});
      add(164, '{busy: 1, write: 1, x_rd_address: 24, out_index: 24, default: 0});
      add(165, '{busy: 1, out_valid: 1, default: 0});
      add(166, '{busy: 1, out_valid: 1, out_rd_address: 1, default: 0});
      add(264, '{busy: 1, out_valid: 1, out_rd_address: 99, default: 0});
      add(265, '{busy: 1, done: 1, default: 0});
      add(266, '{default: 0});

      rst = 1'b1; start = 1'b0; s2_start = 1'b0;
      w_load_valid = 1'b1; x_load_valid = 1'b1; out_ready = 1'b1;
      w_data = 0; x_data = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset obs", sample(), 0);
      chk("reset obs stride2", sample2(), 0);
      rst = 1'b0;

      run_pass("nominal", 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 0);
      run_pass("backpressure", 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1);
      run_pass("reset_mid_mac", 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 2);
      run_pass("after_reset", 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b1, 3);
      run_pass("chained", 1'b0, 1'b1, 1'b0, -1, 1'b1, 1'b0, 4);
      run_stride();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/conv1d_layer_sequencer.md
Name: conv1d_layer_sequencer

Overview:
Top-level controller for one Conv1D multiple-kernel layer. It sequences the full pass from a single start pulse:
- loads the weight buffer and the input buffer from ready/valid load streams;
- steps the MAC datapath through every window with clear/accumulate/write strobes;
- drains the output buffer over a ready/valid stream;
- pulses done at the end.

It sits between the host-side load/unload logic and the 4-lane MAC + buffer datapath.

Parameters:
- KERNEL_SIZE, 3, taps per kernel
- KERNELS, 4, parallel kernels (MAC lanes)
- STRIDE, 1, input step between windows
- INPUT_SIZE, 27, input samples per pass
- W_BUFFER_ADDRESS_BITS, 4, weight buffer address width; must hold KERNELS*KERNEL_SIZE
- INPUT_BUFFER_ADDRESS_BITS, 5, input buffer address width
- OUTPUT_BUFFER_ADDRESS_BITS, 7, output buffer address width; must hold KERNELS*OUT_LEN

Ports:
- clk  in  1  clock; all logic on posedge clk
- rst  in  1  synchronous, active-high reset
- start  in  1  begin pass; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of pass
- w_load_valid  in  1  weight word available
- w_load_ready  out  1  high in LOAD_W
- w_we  out  1  weight buffer write = w_load_valid & w_load_ready
- w_wr_address  out  W_BUFFER_ADDRESS_BITS  weight write address
- x_load_valid  in  1  input sample available
- x_load_ready  out  1  high in LOAD_X
- x_we  out  1  input buffer write = x_load_valid & x_load_ready
- x_wr_address  out  INPUT_BUFFER_ADDRESS_BITS  input write address
- tap  out  W_BUFFER_ADDRESS_BITS  current tap index, 0..KERNEL_SIZE-1
- x_rd_address  out  INPUT_BUFFER_ADDRESS_BITS  window_base + tap
- clear  out  1  zero the accumulators
- mac_en  out  1  accumulate this cycle
- write  out  1  commit accumulators to the output buffer
- out_index  out  OUTPUT_BUFFER_ADDRESS_BITS  current window index; lane k writes at k*OUT_LEN + out_index
- out_rd_address  out  OUTPUT_BUFFER_ADDRESS_BITS  drain read address (output buffer read is combinational)
- out_valid  out  1  drain word valid
- out_ready  in  1  downstream accepts drain word

Behaviour:
- Derived constants:
  - OUT_LEN = (INPUT_SIZE-KERNEL_SIZE)/STRIDE + 1 (25 at defaults)
  - W_WORDS = KERNELS*KERNEL_SIZE (12)
  - O_WORDS = KERNELS*OUT_LEN (100)
- Reset: state=IDLE; all counters 0; every output 0.
- States: IDLE, LOAD_W, LOAD_X, CLEAR, MAC, WRITE, DRAIN, DONE.
- IDLE:
  - start=1 -> LOAD_W.
  - start is ignored in all other states; no queuing.
- LOAD_W:
  - w_load_ready=1; w_wr_address = load counter.
  - On each accepted word the counter increments.
  - Accepting word W_WORDS-1 -> counter cleared, go LOAD_X.
  - valid low stalls with no side effects.
- LOAD_X: same rules as LOAD_W; INPUT_SIZE words; last word -> window_base=0, window=0, go CLEAR.
- CLEAR: one cycle, clear=1 -> MAC with tap=0.
- MAC:
  - KERNEL_SIZE cycles; mac_en=1; x_rd_address = window_base + tap.
  - tap increments each cycle; on tap=KERNEL_SIZE-1 -> WRITE.
- WRITE:
  - one cycle, write=1, out_index=window.
  - If window=OUT_LEN-1 -> DRAIN, drain counter=0.
  - Otherwise window+1, window_base+STRIDE -> CLEAR.
- Per-window cost: KERNEL_SIZE+2 cycles (5 at defaults). Windows reaching past INPUT_SIZE-1 are never issued.
- DRAIN:
  - out_valid=1; out_rd_address = drain counter.
  - out_ready low holds the address and out_valid stable.
  - Each transfer (valid&ready) increments the counter; the transfer at O_WORDS-1 -> DONE.
- DONE: done=1 for one cycle -> IDLE; busy=0 in the next cycle.
- Strobes clear, mac_en, write, w_we, x_we and out_valid are mutually exclusive.
- rst mid-pass: returns to IDLE next edge and drops all strobes. No partial state is kept; buffer contents are left unchanged.
- Arithmetic:
  - Address sums are formed one bit wider and truncated to the port width.
  - Parameter legality is a synthesis-time check, not runtime: OUT_LEN≥1 and all widths sufficient.

Decomposition:
- Shared package conv1d_pkg holds:
  - the state enum;
  - OUT_LEN, W_WORDS and O_WORDS as functions of the parameters;
  - width-check constants reused by the address generator and datapath.
- One sub-module, conv1d_stream_loader: a generic counter + ready/valid write-port driver, instantiated twice (weights, inputs) and reused in spirit for the drain counter.

Test Plan:
- Reset then start with valid/ready held high:
  - LOAD_W occupies 12 cycles and LOAD_X 27.
  - 25 windows × 5 cycles occupy 125 cycles.
  - Drain occupies 100 cycles.
  - done pulses exactly 265 cycles after the start cycle, width 1.
- Compute check: load weights k+1 and inputs 0..26, with a reference model of accumulators driven by clear/mac_en/write.
  - Window 0: x_rd_address sequence 0,1,2, out_index 0.
  - Window 24: x_rd_address 24,25,26, out_index 24.
  - Output buffer matches the golden conv.
- Backpressure: toggle w_load_valid 1/0 and out_ready 1/0 every cycle.
  - w_wr_address advances only on accepted words.
  - out_rd_address holds while out_ready=0.
  - All 12 weight words and 100 output words transfer in order.
- Stride: STRIDE=2 build gives OUT_LEN=13; window_base runs 0,2,…,24; last x_rd_address is 26.
- Reset mid-MAC at window 10: next cycle state is IDLE and all outputs are 0. A new start completes a full pass with correct results.
- start pulsed during DRAIN is ignored; only one done pulse occurs; start in the cycle after done begins a new pass.
